writeback_arbiter: RTL and testbench
====================================

WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 2, long-result buffer entries; legal values 2 and 4.
REQ-002 SHALL have port clock  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port pipeWriteEnabled  input  1  single-cycle pipeline writeback request.
REQ-005 SHALL have ports pipeWriteAddress  input  5 and pipeWriteData  input  32  pipeline destination and value.
REQ-006 SHALL have port longValid  input  1  long-latency unit result valid.
REQ-007 SHALL have port longReady  output  1  buffer can accept a long result.
REQ-008 SHALL have ports longWriteAddress  input  5 and longWriteData  input  32  long result destination and value.
REQ-009 SHALL have ports issueValid  input  1 and issueAddress  input  5  long operation issued; marks destination pending.
REQ-010 SHALL have port pendingMask  output  32  bit i set = register i awaiting long result; bit 0 always 0.
REQ-011 SHALL have ports writeEnabled  output  1, writeAddress  output  5, writeData  output  32  registered register-file write port.
REQ-012 SHALL have port bufferCount  output  3  occupied buffer entries.

Function
REQ-013 SHALL hold long results in a FIFO of DEPTH entries; push when longValid and longReady at a rising edge.
REQ-014 SHALL drive longReady = (bufferCount < DEPTH), combinational from registered count; no push when full.
REQ-015 SHALL, each edge, load the write port from the pipeline request if pipeWriteEnabled and pipeWriteAddress != 0 (pipeline has priority).
REQ-016 SHALL otherwise pop the FIFO head into the write port if bufferCount > 0; else writeEnabled = 0 next cycle, writeAddress/writeData hold.
REQ-017 SHALL give pipeline latency of 1 cycle (request at edge N, writeEnabled high after edge N) and long-result minimum latency of 2 cycles (push at edge N, pop at edge N+1).
REQ-018 SHALL support push and pop at the same edge; count unchanged, FIFO order preserved.
REQ-019 SHALL wrap read/write pointers modulo DEPTH.
REQ-020 SHALL drop pipeline writes to address 0 (no write issued, no pop blocked).
REQ-021 SHALL accept long results addressed to 0 into the FIFO but pop them with writeEnabled = 0.
REQ-022 SHALL set pendingMask[issueAddress] at the edge where issueValid and issueAddress != 0.
REQ-023 SHALL clear pendingMask[a] at the edge a long result with address a is popped to the write port.
REQ-024 SHALL let set win over clear when both target the same bit at the same edge.
REQ-025 SHALL not alter pendingMask on pipeline writes, including to pending registers.
REQ-026 SHALL keep a repeat issue to an already-pending register set (no counting).

Reset
REQ-027 SHALL, on reset, clear writeEnabled, writeAddress, writeData, pendingMask, bufferCount and both pointers to 0, immediately and asynchronously.
REQ-028 SHALL discard all buffered entries on reset mid-operation; longReady = 1 during and after reset.

Configuration
REQ-029 SHALL, with macro WRITEBACK_FORWARD_EN defined, add ports readAddressA/B  input  5, regDataA/B  input  32, fwdDataA/B  output  32.
REQ-030 SHALL, with WRITEBACK_FORWARD_EN, drive fwdDataX = writeData when writeEnabled and writeAddress == readAddressX != 0, else regDataX (combinational).
REQ-031 SHALL, without WRITEBACK_FORWARD_EN, omit those ports and logic entirely; all other behaviour identical.

Verification
REQ-032 SHALL cover: pipe write r5=0x1234 at edge N -> writeEnabled=1, writeAddress=5, writeData=0x1234 after edge N, 0 after N+1.
REQ-033 SHALL cover: issue r7, long result r7=0xAAAA pushed at edge N, no pipe traffic -> write r7 after edge N+1; pendingMask[7] 1 then 0.
REQ-034 SHALL cover: DEPTH=2, two long pushes during continuous pipe writes -> longReady=0, bufferCount=2; pipe stops -> pops in push order on next two edges.
REQ-035 SHALL cover: issueValid r9 at the same edge r9 long result pops -> pendingMask[9] remains 1.
REQ-036 SHALL cover: reset asserted with bufferCount=2, pendingMask=0x80 -> all outputs 0, longReady=1, no later writes of discarded data.
REQ-037 SHALL cover (WRITEBACK_FORWARD_EN): writeEnabled r3=0x55, readAddressA=3, regDataA=0x11 -> fwdDataA=0x55; readAddressA=0 -> regDataA.

Source files
------------

// File: rtl/writeback_arbiter.sv
// -----------------------------------------------------------------------------
// writeback_arbiter
//
// Merges two sources of register-file writes onto one registered write port:
//   * the main pipeline (single-cycle requests, always highest priority)
//   * a long-latency unit whose results are parked in a small FIFO and drained
//     whenever the pipeline leaves the write port idle.
// A scoreboard (pendingMask) tracks registers that are waiting for a long
// result: bits are set on issue and cleared when the result reaches the port.
//
// Optional feature: define WRITEBACK_FORWARD_EN to add two read-bypass ports
// that forward the value currently on the write port to readers of the same
// register. With the macro undefined those ports and their logic are absent.
//
// Parameters
//   DEPTH            long-result buffer entries (2 or 4)
//
// Ports
//   clock, reset                      clock, asynchronous active-high reset
//   pipeWriteEnabled/Address/Data     pipeline writeback request
//   longValid/longReady               long-result handshake
//   longWriteAddress/Data             long-result destination and value
//   issueValid/issueAddress           long operation issued (marks pending)
//   pendingMask                       registers awaiting a long result
//   writeEnabled/Address/Data         registered register-file write port
//   bufferCount                       occupied FIFO entries
//   readAddressA/B, regDataA/B,       (WRITEBACK_FORWARD_EN only) bypass
//   fwdDataA/B
// -----------------------------------------------------------------------------
module writeback_arbiter #(
    parameter int DEPTH = 2
) (
    input  logic        clock,
    input  logic        reset,

    input  logic        pipeWriteEnabled,
    input  logic [4:0]  pipeWriteAddress,
    input  logic [31:0] pipeWriteData,

    input  logic        longValid,
    output logic        longReady,
    input  logic [4:0]  longWriteAddress,
    input  logic [31:0] longWriteData,

    input  logic        issueValid,
    input  logic [4:0]  issueAddress,
    output logic [31:0] pendingMask,

    output logic        writeEnabled,
    output logic [4:0]  writeAddress,
    output logic [31:0] writeData,
    output logic [2:0]  bufferCount
`ifdef WRITEBACK_FORWARD_EN
    ,
    input  logic [4:0]  readAddressA,
    input  logic [4:0]  readAddressB,
    input  logic [31:0] regDataA,
    input  logic [31:0] regDataB,
    output logic [31:0] fwdDataA,
    output logic [31:0] fwdDataB
`endif
);

    localparam int         PTR_W     = (DEPTH > 2) ? 2 : 1;
    localparam logic [2:0] DEPTH_CNT = 3'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [4:0]        addr_mem [DEPTH];
    logic [31:0]       data_mem [DEPTH];

    logic [PTR_W-1:0]  rd_ptr_reg, rd_ptr_next;
    logic [PTR_W-1:0]  wr_ptr_reg, wr_ptr_next;
    logic [2:0]        count_reg, count_next;

    logic              we_reg, we_next;
    logic [4:0]        wa_reg, wa_next;
    logic [31:0]       wd_reg, wd_next;

    logic [31:0]       pending_reg, pending_next;

    // -------------------------------------------------------------------------
    // Arbitration
    // -------------------------------------------------------------------------
    logic        pipe_go;
    logic        push;
    logic        pop;
    logic        pop_writes;
    logic        issue_go;
    logic [4:0]  head_addr;
    logic [31:0] head_data;

    // Head is read asynchronously so an entry pushed at one edge can be
    // popped at the very next edge (two-cycle minimum long latency).
    assign head_addr = addr_mem[rd_ptr_reg];
    assign head_data = data_mem[rd_ptr_reg];

    assign longReady = (count_reg < DEPTH_CNT);

    // Writes to r0 are architecturally void: they neither reach the port nor
    // block the FIFO from draining.
    assign pipe_go    = pipeWriteEnabled && (pipeWriteAddress != 5'd0);
    assign push       = longValid && longReady;
    assign pop        = !pipe_go && (count_reg != 3'd0);
    // An r0 long result is still consumed from the FIFO, just never written.
    assign pop_writes = pop && (head_addr != 5'd0);
    assign issue_go   = issueValid && (issueAddress != 5'd0);

    // -------------------------------------------------------------------------
    // FIFO pointers and occupancy
    // -------------------------------------------------------------------------
    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;

        if (push) begin
            wr_ptr_next = (wr_ptr_reg == PTR_LAST) ? '0 : wr_ptr_reg + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_next = (rd_ptr_reg == PTR_LAST) ? '0 : rd_ptr_reg + PTR_W'(1);
        end

        case ({push, pop})
            2'b10:   count_next = count_reg + 3'd1;
            2'b01:   count_next = count_reg - 3'd1;
            default: count_next = count_reg;
        endcase
    end

    // Storage has no reset: stale contents are unreachable once the pointers
    // and count are cleared.
    always_ff @(posedge clock) begin
        if (push) begin
            addr_mem[wr_ptr_reg] <= longWriteAddress;
            data_mem[wr_ptr_reg] <= longWriteData;
        end
    end

    // -------------------------------------------------------------------------
    // Write port
    // -------------------------------------------------------------------------
    always_comb begin
        we_next = 1'b0;
        wa_next = wa_reg;
        wd_next = wd_reg;

        if (pipe_go) begin
            we_next = 1'b1;
            wa_next = pipeWriteAddress;
            wd_next = pipeWriteData;
        end else if (pop_writes) begin
            we_next = 1'b1;
            wa_next = head_addr;
            wd_next = head_data;
        end
    end

    // -------------------------------------------------------------------------
    // Pending scoreboard: set has priority over clear on the same bit, and
    // pipeline writes never touch it. Bit 0 is hard-wired low.
    // -------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_pending
            if (gi == 0) begin : g_zero
                assign pending_next[gi] = 1'b0;
            end else begin : g_bit
                logic set_hit;
                logic clr_hit;
                assign set_hit = issue_go && (issueAddress == 5'(gi));
                assign clr_hit = pop_writes && (head_addr == 5'(gi));
                assign pending_next[gi] = set_hit | (pending_reg[gi] & ~clr_hit);
            end
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr_reg  <= '0;
            wr_ptr_reg  <= '0;
            count_reg   <= 3'd0;
            we_reg      <= 1'b0;
            wa_reg      <= 5'd0;
            wd_reg      <= 32'd0;
            pending_reg <= 32'd0;
        end else begin
            rd_ptr_reg  <= rd_ptr_next;
            wr_ptr_reg  <= wr_ptr_next;
            count_reg   <= count_next;
            we_reg      <= we_next;
            wa_reg      <= wa_next;
            wd_reg      <= wd_next;
            pending_reg <= pending_next;
        end
    end

    assign writeEnabled = we_reg;
    assign writeAddress = wa_reg;
    assign writeData    = wd_reg;
    assign bufferCount  = count_reg;
    assign pendingMask  = pending_reg;

`ifdef WRITEBACK_FORWARD_EN
    // -------------------------------------------------------------------------
    // Bypass: a reader of the register being written this cycle sees the new
    // value instead of the stale register-file output. r0 never forwards.
    // -------------------------------------------------------------------------
    assign fwdDataA = (we_reg && (wa_reg != 5'd0) && (wa_reg == readAddressA))
                      ? wd_reg : regDataA;
    assign fwdDataB = (we_reg && (wa_reg != 5'd0) && (wa_reg == readAddressB))
                      ? wd_reg : regDataB;
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
// -----------------------------------------------------------------------------
// tb_writeback_arbiter
//
// Directed scenarios with literal expectations, followed by a random phase.
// A queue-based reference model of the arbiter is compared against the DUT on
// every falling edge. Define WRITEBACK_FORWARD_EN to also exercise the bypass.
// -----------------------------------------------------------------------------
module tb_writeback_arbiter;

    localparam int DEPTH = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        pipeWriteEnabled = 1'b0;
    logic [4:0]  pipeWriteAddress = 5'd0;
    logic [31:0] pipeWriteData = 32'd0;
    logic        longValid = 1'b0;
    logic        longReady;
    logic [4:0]  longWriteAddress = 5'd0;
    logic [31:0] longWriteData = 32'd0;
    logic        issueValid = 1'b0;
    logic [4:0]  issueAddress = 5'd0;
    logic [31:0] pendingMask;
    logic        writeEnabled;
    logic [4:0]  writeAddress;
    logic [31:0] writeData;
    logic [2:0]  bufferCount;
`ifdef WRITEBACK_FORWARD_EN
    logic [4:0]  readAddressA = 5'd0;
    logic [4:0]  readAddressB = 5'd0;
    logic [31:0] regDataA = 32'd0;
    logic [31:0] regDataB = 32'd0;
    logic [31:0] fwdDataA;
    logic [31:0] fwdDataB;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    writeback_arbiter #(.DEPTH(DEPTH)) dut (
        .clock            (clock),
        .reset            (reset),
        .pipeWriteEnabled (pipeWriteEnabled),
        .pipeWriteAddress (pipeWriteAddress),
        .pipeWriteData    (pipeWriteData),
        .longValid        (longValid),
        .longReady        (longReady),
        .longWriteAddress (longWriteAddress),
        .longWriteData    (longWriteData),
        .issueValid       (issueValid),
        .issueAddress     (issueAddress),
        .pendingMask      (pendingMask),
        .writeEnabled     (writeEnabled),
        .writeAddress     (writeAddress),
        .writeData        (writeData),
        .bufferCount      (bufferCount)
`ifdef WRITEBACK_FORWARD_EN
        ,
        .readAddressA     (readAddressA),
        .readAddressB     (readAddressB),
        .regDataA         (regDataA),
        .regDataB         (regDataB),
        .fwdDataA         (fwdDataA),
        .fwdDataB         (fwdDataB)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // -------------------------------------------------------------------------
    // Reference model: a queue of pending long results plus the port contents.
    // -------------------------------------------------------------------------
    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    ent_t        m_q[$];
    logic        m_we = 1'b0;
    logic [4:0]  m_wa = 5'd0;
    logic [31:0] m_wd = 32'd0;
    logic [31:0] m_mask = 32'd0;

    always @(posedge clock or posedge reset) begin
        int   sz;
        bit   pg;
        bit   ps;
        ent_t h;
        if (reset) begin
            m_q.delete();
            m_we = 1'b0;
            m_wa = 5'd0;
            m_wd = 32'd0;
            m_mask = 32'd0;
        end else begin
            sz = m_q.size();
            pg = pipeWriteEnabled && (pipeWriteAddress != 5'd0);
            ps = longValid && (sz < DEPTH);
            m_we = 1'b0;
            if (pg) begin
                m_we = 1'b1;
                m_wa = pipeWriteAddress;
                m_wd = pipeWriteData;
            end else if (sz > 0) begin
                h = m_q.pop_front();
                if (h.a != 5'd0) begin
                    m_we = 1'b1;
                    m_wa = h.a;
                    m_wd = h.d;
                    m_mask[h.a] = 1'b0;
                end
            end
            if (ps) m_q.push_back('{a: longWriteAddress, d: longWriteData});
            if (issueValid && (issueAddress != 5'd0)) m_mask[issueAddress] = 1'b1;
        end
    end

    always @(negedge clock) begin
        chk("model.writeEnabled", {31'd0, writeEnabled}, {31'd0, m_we});
        if (m_we) begin
            chk("model.writeAddress", {27'd0, writeAddress}, {27'd0, m_wa});
            chk("model.writeData", writeData, m_wd);
        end
        chk("model.pendingMask", pendingMask, m_mask);
        chk("model.bufferCount", {29'd0, bufferCount}, 32'(m_q.size()));
        chk("model.longReady", {31'd0, longReady}, {31'd0, (m_q.size() < DEPTH)});
`ifdef WRITEBACK_FORWARD_EN
        chk("model.fwdDataA", fwdDataA,
            (m_we && m_wa != 5'd0 && m_wa == readAddressA) ? m_wd : regDataA);
        chk("model.fwdDataB", fwdDataB,
            (m_we && m_wa != 5'd0 && m_wa == readAddressB) ? m_wd : regDataB);
`endif
    end

    // -------------------------------------------------------------------------
    // Stimulus helpers
    // -------------------------------------------------------------------------
    task automatic tick();
        @(posedge clock);
        #1;
        $display("cycle t=%0t we=%0b wa=%0d wd=0x%0h count=%0d ready=%0b mask=0x%0h",
                 $time, writeEnabled, writeAddress, writeData, bufferCount, longReady, pendingMask);
        pipeWriteEnabled = 1'b0;
        longValid = 1'b0;
        issueValid = 1'b0;
    endtask

    task automatic pipe(input logic [4:0] a, input logic [31:0] d);
        pipeWriteEnabled = 1'b1;
        pipeWriteAddress = a;
        pipeWriteData = d;
    endtask

    task automatic long_res(input logic [4:0] a, input logic [31:0] d);
        longValid = 1'b1;
        longWriteAddress = a;
        longWriteData = d;
    endtask

    task automatic issue(input logic [4:0] a);
        issueValid = 1'b1;
        issueAddress = a;
    endtask

    task automatic port(input string n, input logic we, input logic [4:0] wa, input logic [31:0] wd);
        chk({n, ".we"}, {31'd0, writeEnabled}, {31'd0, we});
        chk({n, ".wa"}, {27'd0, writeAddress}, {27'd0, wa});
        chk({n, ".wd"}, writeData, wd);
    endtask

    initial begin
        // Reset state
        @(posedge clock);
        #1;
        port("reset", 1'b0, 5'd0, 32'd0);
        chk("reset.mask", pendingMask, 32'd0);
        chk("reset.count", {29'd0, bufferCount}, 32'd0);
        chk("reset.ready", {31'd0, longReady}, 32'd1);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Pipeline write: one-cycle latency, single-cycle pulse, data holds
        pipe(5'd5, 32'h1234);
        tick();
        port("pipe.r5", 1'b1, 5'd5, 32'h1234);
        tick();
        port("pipe.idle", 1'b0, 5'd5, 32'h1234);

        // Issue then long result: written one edge after the push
        issue(5'd7);
        tick();
        chk("issue.mask", pendingMask, 32'h80);
        long_res(5'd7, 32'hAAAA);
        tick();
        chk("long.push.we", {31'd0, writeEnabled}, 32'd0);
        chk("long.push.count", {29'd0, bufferCount}, 32'd1);
        chk("long.push.mask", pendingMask, 32'h80);
        tick();
        port("long.pop", 1'b1, 5'd7, 32'hAAAA);
        chk("long.pop.mask", pendingMask, 32'h0);
        chk("long.pop.count", {29'd0, bufferCount}, 32'd0);

        // Fill the buffer behind continuous pipeline traffic
        pipe(5'd1, 32'd1); long_res(5'd2, 32'h22);
        tick();
        chk("fill1.count", {29'd0, bufferCount}, 32'd1);
        chk("fill1.ready", {31'd0, longReady}, 32'd1);
        pipe(5'd1, 32'd2); long_res(5'd3, 32'h33);
        tick();
        chk("fill2.count", {29'd0, bufferCount}, 32'd2);
        chk("fill2.ready", {31'd0, longReady}, 32'd0);
        pipe(5'd1, 32'd3); long_res(5'd4, 32'h44);   // dropped: buffer full
        tick();
        chk("full.count", {29'd0, bufferCount}, 32'd2);
        port("full.pipe", 1'b1, 5'd1, 32'd3);
        tick();                                       // pipeline stops: drain
        port("drain1", 1'b1, 5'd2, 32'h22);
        chk("drain1.count", {29'd0, bufferCount}, 32'd1);
        long_res(5'd4, 32'h44);                       // push and pop together
        tick();
        port("drain2", 1'b1, 5'd3, 32'h33);
        chk("pushpop.count", {29'd0, bufferCount}, 32'd1);
        tick();
        port("drain3", 1'b1, 5'd4, 32'h44);
        tick();
        port("drained", 1'b0, 5'd4, 32'h44);

        // r0 handling: long r0 consumed silently, pipe r0 does not block a pop
        long_res(5'd0, 32'h5);
        tick();
        chk("r0.push.count", {29'd0, bufferCount}, 32'd1);
        pipe(5'd0, 32'h77); long_res(5'd6, 32'h66);
        tick();
        port("r0.pop", 1'b0, 5'd4, 32'h44);
        chk("r0.pop.count", {29'd0, bufferCount}, 32'd1);
        pipe(5'd0, 32'h78);
        tick();
        port("r0.pipe.pop", 1'b1, 5'd6, 32'h66);

        // Set wins over clear on the same register
        issue(5'd9); long_res(5'd9, 32'h99);
        tick();
        chk("r9.set", pendingMask, 32'h200);
        issue(5'd9);
        tick();
        port("r9.pop", 1'b1, 5'd9, 32'h99);
        chk("r9.setwins", pendingMask, 32'h200);
        pipe(5'd9, 32'h1);                            // pipe write leaves mask alone
        tick();
        chk("r9.pipe", pendingMask, 32'h200);
        long_res(5'd9, 32'h9A);
        tick();
        tick();
        chk("r9.clear", pendingMask, 32'h0);

        // Reset mid-operation discards the buffer
        issue(5'd7);
        tick();
        pipe(5'd1, 32'h10); long_res(5'd7, 32'h70);
        tick();
        pipe(5'd1, 32'h11); long_res(5'd7, 32'h71);
        tick();
        chk("prerst.count", {29'd0, bufferCount}, 32'd2);
        chk("prerst.mask", pendingMask, 32'h80);
        #2;
        reset = 1'b1;
        #1;
        port("rst.async", 1'b0, 5'd0, 32'd0);
        chk("rst.mask", pendingMask, 32'd0);
        chk("rst.count", {29'd0, bufferCount}, 32'd0);
        chk("rst.ready", {31'd0, longReady}, 32'd1);
        @(posedge clock);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            port("postrst", 1'b0, 5'd0, 32'd0);
            chk("postrst.count", {29'd0, bufferCount}, 32'd0);
        end

`ifdef WRITEBACK_FORWARD_EN
        pipe(5'd3, 32'h55);
        tick();
        readAddressA = 5'd3; regDataA = 32'h11;
        readAddressB = 5'd4; regDataB = 32'h22;
        #1;
        chk("fwdA.hit", fwdDataA, 32'h55);
        chk("fwdB.miss", fwdDataB, 32'h22);
        readAddressA = 5'd0;
        #1;
        chk("fwdA.r0", fwdDataA, 32'h11);
`endif

        // Random traffic checked by the model
        for (int i = 0; i < 400; i++) begin
            pipeWriteEnabled = ($urandom_range(0, 2) == 0);
            pipeWriteAddress = 5'($urandom_range(0, 7));
            pipeWriteData    = $urandom;
            longValid        = ($urandom_range(0, 1) == 0);
            longWriteAddress = 5'($urandom_range(0, 7));
            longWriteData    = $urandom;
            issueValid       = ($urandom_range(0, 2) == 0);
            issueAddress     = 5'($urandom_range(0, 7));
`ifdef WRITEBACK_FORWARD_EN
            readAddressA = 5'($urandom_range(0, 7));
            readAddressB = 5'($urandom_range(0, 7));
            regDataA     = $urandom;
            regDataB     = $urandom;
`endif
            tick();
        end

        @(negedge clock);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
